// File: rtl/ctrl_pkg.sv
// Shared control definitions for the multicycle main FSM:
// state encoding, ALU operations, opcodes and datapath mux selects.
package ctrl_pkg;

    localparam int OPW    = 2;
    localparam int FUNCTW = 6;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [OPW-1:0] OP_DP  = 2'b00;
    localparam logic [OPW-1:0] OP_MEM = 2'b01;
    localparam logic [OPW-1:0] OP_BR  = 2'b10;

    localparam logic       SRC_ADR_PC  = 1'b0;
    localparam logic       SRC_ADR_ALU = 1'b1;

    localparam logic [1:0] SRC_A_REG    = 2'b00;
    localparam logic [1:0] SRC_A_PC     = 2'b01;
    localparam logic [1:0] SRC_A_ALUOUT = 2'b10;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] SRC_RES_ALUOUT = 2'b00;
    localparam logic [1:0] SRC_RES_DATA   = 2'b01;
    localparam logic [1:0] SRC_RES_ALU    = 2'b10;

endpackage

// File: rtl/main_fsm_if.sv
// Instruction fields in, control requests and mux selects out.
// master = control FSM side, slave = datapath/condition side.
interface main_fsm_if;
    import ctrl_pkg::*;

    logic [OPW-1:0]    Op;
    logic [FUNCTW-1:0] Funct;
    logic [3:0]        Rd;
    logic              IRWrite;
    logic              NextPC;
    logic              AdrSrc;
    logic [1:0]        ALUSrcA;
    logic [1:0]        ALUSrcB;
    logic [1:0]        ResultSrc;
    logic [1:0]        ALUControl;
    logic [1:0]        FlagW;
    logic              PCS;
    logic              RegW;
    logic              MemW;
    logic              IllegalOp;

    modport master (
        input  Op, Funct, Rd,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB,
        output ResultSrc, ALUControl, FlagW,
        output PCS, RegW, MemW, IllegalOp
    );

    modport slave (
        output Op, Funct, Rd,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB,
        input  ResultSrc, ALUControl, FlagW,
        input  PCS, RegW, MemW, IllegalOp
    );

endinterface

// File: rtl/alu_decoder.sv
// Maps Funct to ALU operation and flag-write request during execute.
// Unsupported Funct[4:1] falls back to ADD and flags bad_funct.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic       alu_op,
    input  logic [4:0] funct,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       bad_funct
);

    logic [1:0] ctl;
    logic       bad;

    always_comb begin
        ctl = ALU_ADD;
        bad = 1'b0;
        unique case (1'b1)
            (funct[4:1] == 4'b0100): ctl = ALU_ADD;
            (funct[4:1] == 4'b0010): ctl = ALU_SUB;
            (funct[4:1] == 4'b0000): ctl = ALU_AND;
            (funct[4:1] == 4'b1100): ctl = ALU_ORR;
            default:                 bad = 1'b1;
        endcase
    end

    // C,V only mean something for the arithmetic ops
    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        bad_funct   = 1'b0;
        if (alu_op) begin
            alu_control = ctl;
            bad_funct   = bad;
            flag_w[1]   = funct[0];
            flag_w[0]   = funct[0] & ((ctl == ALU_ADD) | (ctl == ALU_SUB));
        end
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback
// and emits unconditioned write requests for the condition stage.
module main_fsm (
    input  logic        clk,
    input  logic        reset,
    main_fsm_if.master  bus
);
    import ctrl_pkg::*;

    state_t     state;
    state_t     state_n;

    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       illegal_st;
    logic [1:0] alu_control;
    logic [1:0] flag_w;
    logic       bad_funct;
    logic       pcs;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    always_comb begin
        state_n = FETCH;
        unique case (state)
            FETCH:  state_n = DECODE;
            DECODE: begin
                unique case (bus.Op)
                    OP_MEM:  state_n = MEMADR;
                    OP_DP:   state_n = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   state_n = BRANCH;
                    default: state_n = UNKNOWN;
                endcase
            end
            MEMADR:   state_n = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_n = MEMWB;
            EXECUTER: state_n = ALUWB;
            EXECUTEI: state_n = ALUWB;
            default:  state_n = FETCH;
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        adr_src    = SRC_ADR_PC;
        src_a      = SRC_A_REG;
        src_b      = SRC_B_REG;
        res_src    = SRC_RES_ALUOUT;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        illegal_st = 1'b0;
        unique case (state)
            FETCH: begin
                ir_write = 1'b1;
                next_pc  = 1'b1;
                src_a    = SRC_A_PC;
                src_b    = SRC_B_FOUR;
                res_src  = SRC_RES_ALU;
            end
            DECODE: begin
                src_a   = SRC_A_PC;
                src_b   = SRC_B_FOUR;
                res_src = SRC_RES_ALU;
            end
            MEMADR: src_b = SRC_B_IMM;
            MEMRD:  adr_src = SRC_ADR_ALU;
            MEMWB: begin
                res_src = SRC_RES_DATA;
                reg_w   = 1'b1;
            end
            MEMWR: begin
                adr_src = SRC_ADR_ALU;
                mem_w   = 1'b1;
            end
            EXECUTER: alu_op = 1'b1;
            EXECUTEI: begin
                src_b  = SRC_B_IMM;
                alu_op = 1'b1;
            end
            ALUWB: reg_w = 1'b1;
            BRANCH: begin
                src_a   = SRC_A_ALUOUT;
                src_b   = SRC_B_IMM;
                res_src = SRC_RES_ALU;
                branch  = 1'b1;
            end
            UNKNOWN: illegal_st = 1'b1;
            default: ;
        endcase
    end

    alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct       (bus.Funct[4:0]),
        .alu_control (alu_control),
        .flag_w      (flag_w),
        .bad_funct   (bad_funct)
    );

    assign pcs = branch | (reg_w & (bus.Rd == 4'hF));

    // Requests are suppressed while reset is held; selects are not
    assign bus.IRWrite    = ir_write & ~reset;
    assign bus.NextPC     = next_pc & ~reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ResultSrc  = res_src;
    assign bus.ALUControl = alu_control;
    assign bus.FlagW      = reset ? 2'b00 : flag_w;
    assign bus.PCS        = pcs & ~reset;
    assign bus.RegW       = reg_w & ~reset;
    assign bus.MemW       = mem_w & ~reset;
    assign bus.IllegalOp  = (illegal_st | bad_funct) & ~reset;

endmodule

// File: tb/tb_main_fsm.sv
// Random instruction stream against a per-instruction step model,
// with occasional reset injected mid-instruction.
module tb_main_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    main_fsm_if bus ();

    main_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir;
        logic       np;
        logic       adr;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] res;
        logic [1:0] ctl;
        logic [1:0] fw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       ill;
    } outs_t;

    // steps of an instruction as the spec names them
    typedef enum int {
        S_F, S_D, S_ADR, S_RD, S_MWB, S_WR, S_XR, S_XI, S_AWB, S_BR, S_UNK
    } step_t;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic outs_t observe();
        outs_t o;
        o.ir   = bus.IRWrite;
        o.np   = bus.NextPC;
        o.adr  = bus.AdrSrc;
        o.a    = bus.ALUSrcA;
        o.b    = bus.ALUSrcB;
        o.res  = bus.ResultSrc;
        o.ctl  = bus.ALUControl;
        o.fw   = bus.FlagW;
        o.pcs  = bus.PCS;
        o.regw = bus.RegW;
        o.memw = bus.MemW;
        o.ill  = bus.IllegalOp;
        return o;
    endfunction

    function automatic outs_t gate(input outs_t e);
        outs_t g = e;
        g.ir   = 1'b0;
        g.np   = 1'b0;
        g.fw   = 2'b00;
        g.pcs  = 1'b0;
        g.regw = 1'b0;
        g.memw = 1'b0;
        g.ill  = 1'b0;
        return g;
    endfunction

    function automatic void alu_ref(input logic [5:0] fn, output logic [1:0] ctl,
                                    output logic [1:0] fw, output logic bad);
        int code = int'(fn[4:1]);
        bad = 1'b0;
        if (code == 4)       ctl = 2'd0;
        else if (code == 2)  ctl = 2'd1;
        else if (code == 0)  ctl = 2'd2;
        else if (code == 12) ctl = 2'd3;
        else begin
            ctl = 2'd0;
            bad = 1'b1;
        end
        fw[1] = fn[0];
        fw[0] = fn[0] && (ctl < 2'd2);
    endfunction

    function automatic outs_t expect_step(input step_t s, input logic [5:0] fn,
                                          input logic [3:0] rd);
        outs_t e = '0;
        logic  bad;
        case (s)
            S_F:   begin e.ir = 1; e.np = 1; e.a = 1; e.b = 2; e.res = 2; end
            S_D:   begin e.a = 1; e.b = 2; e.res = 2; end
            S_ADR: e.b = 1;
            S_RD:  e.adr = 1;
            S_MWB: begin e.res = 1; e.regw = 1; e.pcs = (rd == 15); end
            S_WR:  begin e.adr = 1; e.memw = 1; end
            S_XR, S_XI: begin
                alu_ref(fn, e.ctl, e.fw, bad);
                e.ill = bad;
                if (s == S_XI) e.b = 1;
            end
            S_AWB: begin e.regw = 1; e.pcs = (rd == 15); end
            S_BR:  begin e.a = 2; e.b = 1; e.res = 2; e.pcs = 1; end
            S_UNK: e.ill = 1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic void build(input logic [1:0] op, input logic [5:0] fn,
                                  output step_t q[$]);
        q = {S_F, S_D};
        case (op)
            2'd1: begin
                q.push_back(S_ADR);
                if (fn[0]) q = {q, S_RD, S_MWB};
                else       q.push_back(S_WR);
            end
            2'd0: q = {q, (fn[5] ? S_XI : S_XR), S_AWB};
            2'd2: q.push_back(S_BR);
            default: q.push_back(S_UNK);
        endcase
    endfunction

    // called at a negedge with the DUT in FETCH; rst_at<0 means no reset
    task automatic run_instr(input string tag, input logic [1:0] op,
                             input logic [5:0] fn, input logic [3:0] rd,
                             input int rst_at);
        step_t q[$];
        outs_t e;
        build(op, fn, q);
        bus.Op    = op;
        bus.Funct = fn;
        bus.Rd    = rd;
        for (int i = 0; i < q.size(); i++) begin
            e = expect_step(q[i], fn, rd);
            if (i == rst_at) begin
                reset = 1'b1;
                #1;
                check({tag, "_rst"}, 32'(observe()), 32'(gate(e)));
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            #1;
            check($sformatf("%s_s%0d", tag, i), 32'(observe()), 32'(e));
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        outs_t e;
        bus.Op    = 2'b01;
        bus.Funct = 6'b011001;
        bus.Rd    = 4'd3;
        reset     = 1'b1;
        #1;
        e = observe();
        check("rst0_en", {e.ir, e.np, e.fw, e.pcs, e.regw, e.memw, e.ill}, 32'd0);
        @(negedge clk);
        check("rst1", 32'(observe()), 32'(gate(expect_step(S_F, 6'd0, 4'd0))));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_instr("ldr",    2'b01, 6'b011001, 4'd3,  -1);
        run_instr("ldr_pc", 2'b01, 6'b011001, 4'd15, -1);
        run_instr("str",    2'b01, 6'b011000, 4'd2,  -1);
        run_instr("subs_i", 2'b00, 6'b100101, 4'd1,  -1);
        run_instr("ands_r", 2'b00, 6'b000001, 4'd15, -1);
        run_instr("b",      2'b10, 6'b000000, 4'd0,  -1);
        run_instr("undef",  2'b11, 6'b010101, 4'd15, -1);
        run_instr("str_rst", 2'b01, 6'b011000, 4'd4, 3);
        run_instr("badfn",  2'b00, 6'b001110, 4'd5,  -1);
        run_instr("orr_i",  2'b00, 6'b111001, 4'd15, -1);

        for (int n = 0; n < 400; n++) begin
            logic [1:0] op = 2'($urandom_range(0, 3));
            logic [5:0] fn = 6'($urandom);
            logic [3:0] rd = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            int rs = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr($sformatf("rnd%0d", n), op, fn, rd, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
